// File: rtl/timer_counter_pkg.sv
// rtl/timer_counter_pkg.sv - Register map, CTRL layout and FSM encoding for timer_counter
package timer_counter_pkg;

    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;

    localparam int TC_EN      = 0;
    localparam int TC_MODE_LO = 1;
    localparam int TC_MODE_HI = 2;
    localparam int TC_IM      = 3;

    localparam logic [1:0] TC_MODE_ONESHOT = 2'd0;
    localparam logic [1:0] TC_MODE_RELOAD  = 2'd1;

    typedef enum logic [1:0] {
        TC_IDLE = 2'd0,
        TC_LOAD = 2'd1,
        TC_CNT  = 2'd2,
        TC_INT  = 2'd3
    } tc_state_e;

    function automatic logic [31:0] tc_ctrl_rdata(input logic [3:0] ctrl);
        return {28'd0, ctrl};
    endfunction

endpackage

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - Memory-mapped down-counting timer with CTRL/PRESET/COUNT and interrupt
module timer_counter
    import timer_counter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;
    tc_state_e   state_q, state_d;

    logic [1:0]  offset;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        fsm_clr_en;
    logic        addr_unused;

    // The bridge decodes the window base; only the word offset matters here.
    assign offset      = addr[3:2];
    assign addr_unused = ^{addr[31:4], addr[1:0]};
    assign wr_ctrl     = we && (offset == TC_CTRL);
    assign wr_preset   = we && (offset == TC_PRESET);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
        fsm_clr_en = 1'b0;
        case (state_q)
            TC_IDLE: begin
                if (ctrl_q[TC_EN]) begin
                    irq_flag_d = 1'b0;
                    state_d    = TC_LOAD;
                end
            end
            TC_LOAD: begin
                count_d = preset_q;
                state_d = TC_CNT;
            end
            TC_CNT: begin
                // Expiry at COUNT<=1 also covers PRESET=0 and keeps COUNT from wrapping.
                if (!ctrl_q[TC_EN]) begin
                    state_d = TC_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = 32'd0;
                    irq_flag_d = 1'b1;
                    state_d    = TC_INT;
                end
            end
            TC_INT: begin
                state_d = TC_IDLE;
                if (ctrl_q[TC_MODE_HI:TC_MODE_LO] == TC_MODE_RELOAD) begin
                    irq_flag_d = 1'b0;
                end else begin
                    fsm_clr_en = 1'b1;
                end
            end
            default: state_d = TC_IDLE;
        endcase
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        if (fsm_clr_en) begin
            ctrl_d[TC_EN] = 1'b0;
        end
        // A CPU write to CTRL overrides the one-shot EN clear on the same edge.
        if (wr_ctrl) begin
            ctrl_d = din[3:0];
        end
        if (wr_preset) begin
            preset_d = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
            state_q    <= TC_IDLE;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        dout = 32'd0;
        case (offset)
            TC_CTRL:   dout = tc_ctrl_rdata(ctrl_q);
            TC_PRESET: dout = preset_q;
            TC_COUNT:  dout = count_q;
            default:   dout = 32'd0;
        endcase
    end

    assign irq = ctrl_q[TC_IM] & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - Randomized and directed self-checking bench for timer_counter
module tb_timer_counter;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    timer_counter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: timer phase as a name, registers as plain values.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    longint      m_count;
    bit          m_flag;
    string       m_ph;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl   = 4'd0;
        m_preset = 32'd0;
        m_count  = 0;
        m_flag   = 1'b0;
        m_ph     = "idle";
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] o);
        if (o == 2'd0) return {28'd0, m_ctrl};
        if (o == 2'd1) return m_preset;
        if (o == 2'd2) return m_count[31:0];
        return 32'd0;
    endfunction

    function automatic logic model_irq();
        return m_ctrl[3] & m_flag;
    endfunction

    task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d);
        bit enabled;
        bit reload;
        enabled = m_ctrl[0];
        reload  = (m_ctrl[2:1] == 2'd1);
        if (m_ph == "idle") begin
            if (enabled) begin
                m_flag = 1'b0;
                m_ph   = "load";
            end
        end else if (m_ph == "load") begin
            m_count = m_preset;
            m_ph    = "run";
        end else if (m_ph == "run") begin
            if (!enabled) m_ph = "idle";
            else if (m_count > 1) m_count = m_count - 1;
            else begin
                m_count = 0;
                m_flag  = 1'b1;
                m_ph    = "expired";
            end
        end else begin
            m_ph = "idle";
            if (reload) m_flag = 1'b0;
            else m_ctrl[0] = 1'b0;
        end
        if (w && a[3:2] == 2'd0) m_ctrl = d[3:0];
        if (w && a[3:2] == 2'd1) m_preset = d;
    endtask

    task automatic sweep(input string tag);
        for (int o = 0; o < 4; o++) begin
            addr = ($urandom & 32'hFFFF_FFF3) | (o << 2);
            #1;
            check_eq({tag, "_rd"}, dout, model_read(o[1:0]));
        end
        check_eq({tag, "_irq"}, {31'd0, irq}, {31'd0, model_irq()});
    endtask

    task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d);
        we   = w;
        addr = a;
        din  = d;
        #1;
        check_eq("rd_before_edge", dout, model_read(a[3:2]));
        model_step(w, a, d);
        @(posedge clk);
        #1;
        we = 1'b0;
        sweep("cyc");
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 32'd0, $urandom);
    endtask

    task automatic peek(input logic [1:0] o, output logic [31:0] v);
        addr = {28'd0, o, 2'b00};
        #1;
        v = dout;
    endtask

    task automatic settle();
        cycle(1'b1, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) idle_cycle();
    endtask

    initial begin
        logic [31:0] v;
        int first_rise;
        int highs;
        bit prev_irq;
        int rises[$];

        rst_n = 1'b0;
        we    = 1'b0;
        addr  = 32'd0;
        din   = 32'd0;
        model_reset();
        #2;
        sweep("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // One-shot, PRESET=3: count 3,2,1,0 from edge 2, irq rises at edge 5.
        cycle(1'b1, 32'h4, 32'd3);
        cycle(1'b1, 32'h0, 32'h9);
        first_rise = 0;
        for (int k = 1; k <= 8; k++) begin
            idle_cycle();
            if (irq && first_rise == 0) first_rise = k;
            if (k >= 2 && k <= 5) begin
                peek(2'd2, v);
                check_eq("oneshot_cnt", v, 32'(5 - k));
            end
        end
        check_eq("oneshot_rise", 32'(first_rise), 32'd5);
        check_eq("oneshot_irq_held", {31'd0, irq}, 32'd1);
        peek(2'd0, v);
        check_eq("oneshot_ctrl", v, 32'h8);

        // Re-arm a one-shot: irq drops one edge after the write, count restarts.
        cycle(1'b1, 32'h0, 32'h9);
        check_eq("rearm_irq_still", {31'd0, irq}, 32'd1);
        idle_cycle();
        check_eq("rearm_irq_drop", {31'd0, irq}, 32'd0);
        idle_cycle();
        peek(2'd2, v);
        check_eq("rearm_cnt", v, 32'd3);
        settle();

        // Auto-reload, PRESET=2: 1-cycle irq pulses every 5 cycles.
        cycle(1'b1, 32'h4, 32'd2);
        cycle(1'b1, 32'h0, 32'hB);
        rises.delete();
        highs    = 0;
        prev_irq = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            idle_cycle();
            if (irq) highs++;
            if (irq && !prev_irq) rises.push_back(k);
            prev_irq = irq;
        end
        check_eq("reload_nrises", 32'(rises.size()), 32'd5);
        check_eq("reload_width", 32'(highs), 32'(rises.size()));
        check_eq("reload_first", 32'(rises.size() > 0 ? rises[0] : -1), 32'd4);
        for (int i = 1; i < rises.size(); i++)
            check_eq("reload_period", 32'(rises[i] - rises[i-1]), 32'd5);
        settle();

        // PRESET rewrite mid-count applies only at the next reload.
        cycle(1'b1, 32'h4, 32'd4);
        cycle(1'b1, 32'h0, 32'hB);
        rises.delete();
        prev_irq = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 4) cycle(1'b1, 32'h4, 32'd7);
            else idle_cycle();
            if (irq && !prev_irq) rises.push_back(k);
            prev_irq = irq;
        end
        check_eq("preset_rise0", 32'(rises.size() > 0 ? rises[0] : -1), 32'd6);
        check_eq("preset_rise1", 32'(rises.size() > 1 ? rises[1] : -1), 32'd16);
        settle();

        // Asynchronous reset mid-count with COUNT=5.
        cycle(1'b1, 32'h4, 32'd9);
        cycle(1'b1, 32'h0, 32'h1);
        for (int k = 1; k <= 6; k++) idle_cycle();
        peek(2'd2, v);
        check_eq("pre_reset_cnt", v, 32'd5);
        rst_n = 1'b0;
        model_reset();
        #1;
        peek(2'd2, v);
        check_eq("async_rst_cnt", v, 32'd0);
        peek(2'd0, v);
        check_eq("async_rst_ctrl", v, 32'd0);
        check_eq("async_rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 32'h8, 32'h1234_5678);
        peek(2'd2, v);
        check_eq("count_readonly", v, 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic        w;
            w = ($urandom_range(0, 7) == 0);
            a = $urandom;
            d = $urandom;
            if (a[3:2] == 2'd1) d = $urandom_range(0, 6);
            cycle(w, a, d);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
